// File: rtl/sum_uart_tx.sv
// sum_uart_tx: buffers adder result bytes in a small FIFO and serializes
// each one onto a UART TX line (8N1, LSB first, idles high).
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   in_data     result byte from the adder stage
//   in_valid    in_data valid this cycle
//   in_ready    FIFO can accept a byte this cycle (combinational)
//   tx          registered UART serial output
//   busy        frame in progress or FIFO non-empty
//   fifo_count  bytes currently buffered
//
// Optional feature: define SUM_UART_TX_PARITY_EN to insert an even-parity
// bit between the data bits and the stop bit (11 bit periods per frame).
module sum_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef SUM_UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;

  logic [2:0]       state, state_d;
  logic [TMR_W-1:0] timer, timer_d;
  logic [2:0]       bit_idx, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_d;
  logic             timer_last;
`ifdef SUM_UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign in_ready   = !reset && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign busy       = (state != IDLE) || (fifo_count != '0);
  assign timer_last = (timer == TMR_W'(CLKS_PER_BIT - 1));

  // FIFO storage; a full FIFO refuses pushes even when a pop is pending
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    state_d = state;
    timer_d = timer;
    bit_d   = bit_idx;
    shift_d = shift_q;
    tx_d    = tx;
    pop     = 1'b0;
`ifdef SUM_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (fifo_count != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          tx_d    = 1'b0;
          timer_d = '0;
          bit_d   = '0;
          state_d = START;
`ifdef SUM_UART_TX_PARITY_EN
          parity_d = ^mem[rd_ptr];
`endif
        end
      end
      START: begin
        if (timer_last) begin
          timer_d = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          timer_d = timer + TMR_W'(1);
        end
      end
      DATA: begin
        if (timer_last) begin
          timer_d = '0;
          if (bit_idx == 3'd7) begin
`ifdef SUM_UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            // Next bit is already sitting at shift_q[1]
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_idx + 3'd1;
          end
        end else begin
          timer_d = timer + TMR_W'(1);
        end
      end
`ifdef SUM_UART_TX_PARITY_EN
      PARITY: begin
        if (timer_last) begin
          timer_d = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          timer_d = timer + TMR_W'(1);
        end
      end
`endif
      STOP: begin
        if (timer_last) begin
          timer_d = '0;
          tx_d    = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer + TMR_W'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and FIFO bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      shift_q    <= '0;
      tx         <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
`ifdef SUM_UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      timer   <= timer_d;
      bit_idx <= bit_d;
      shift_q <= shift_d;
      tx      <= tx_d;
`ifdef SUM_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
      else if (!push && pop) fifo_count <= fifo_count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sum_uart_tx.sv
// Self-checking bench for sum_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Reference model: a byte queue plus a position counter within the frame;
// the expected line level is derived from the frame layout.
module tb_sum_uart_tx;

  localparam int C     = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef SUM_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FL = NBITS * C;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             tx;
  logic             busy;
  logic [CNT_W-1:0] fifo_count;

  int n_cmp  = 0;
  int n_fail = 0;

  // model state
  logic [7:0] q[$];
  logic [7:0] cur;
  int         pos = -1;

  sum_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Line level at a given position in the current frame
  function automatic logic frame_bit(int p);
    int b;
    b = p / C;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur[b-1];
`ifdef SUM_UART_TX_PARITY_EN
    if (b == 9) return ^cur;
`endif
    return 1'b1;
  endfunction

  // Expected {tx, busy, in_ready, fifo_count}
  function automatic logic [CNT_W+2:0] exp_vec();
    logic e_tx, e_busy, e_rdy;
    e_tx   = (pos < 0) ? 1'b1 : frame_bit(pos);
    e_busy = (pos >= 0) || (q.size() != 0);
    e_rdy  = !reset && (q.size() < DEPTH);
    return {e_tx, e_busy, e_rdy, CNT_W'(q.size())};
  endfunction

  // Drive one cycle of inputs, advance the model across the edge
  task automatic tick(input logic v, input logic [7:0] d, input logic r);
    bit do_push;
    in_valid = v;
    in_data  = d;
    reset    = r;
    @(posedge clk);
    do_push = v && !r && (q.size() < DEPTH);
    if (r) begin
      q.delete();
      pos = -1;
    end else begin
      if (pos >= 0) begin
        pos++;
        if (pos == FL) pos = -1;
      end else if (q.size() != 0) begin
        cur = q.pop_front();
        pos = 0;
      end
      if (do_push) q.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready_low got=%b want=0", in_ready);
    end
    tick(1'b0, 8'h00, 1'b0);
    n_cmp++;
    if ({tx, busy, in_ready, fifo_count} !== {1'b1, 1'b0, 1'b1, CNT_W'(0)}) begin
      n_fail++;
      $display("FAIL reset_release got tx=%b busy=%b rdy=%b cnt=%0d want 1 0 1 0",
               tx, busy, in_ready, fifo_count);
    end
  endtask

  task automatic test_single();
    logic       obs_tx[FL+2];
    logic       obs_busy[FL+2];
    logic [7:0] rx;
    tick(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < FL + 2; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      obs_tx[i]   = tx;
      obs_busy[i] = busy;
      n_cmp++;
      if ({tx, busy, in_ready, fifo_count} !== exp_vec()) begin
        n_fail++;
        $display("FAIL single_cycle%0d got=%b want=%b", i,
                 {tx, busy, in_ready, fifo_count}, exp_vec());
      end
    end
    for (int b = 0; b < 8; b++) rx[b] = obs_tx[(b + 1) * C + C / 2];
    n_cmp++;
    if (rx !== 8'hA5 || obs_tx[C/2] !== 1'b0 || obs_tx[FL - 1] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_decode got=%h start=%b stop=%b want=a5 0 1",
               rx, obs_tx[C/2], obs_tx[FL-1]);
    end
    n_cmp++;
    if (obs_busy[FL - 1] !== 1'b1 || obs_busy[FL] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_drop got last=%b after=%b want 1 0",
               obs_busy[FL-1], obs_busy[FL]);
    end
  endtask

  task automatic test_fifo_fill();
    int guard;
    bit saw_full = 0;
    for (int i = 1; i <= 5; i++) begin
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_accept%0d in_ready got=%b want=1", i, in_ready);
      end
      tick(1'b1, 8'(i), 1'b0);
      if (fifo_count == CNT_W'(DEPTH) && in_ready == 1'b0) saw_full = 1;
      n_cmp++;
      if ({tx, busy, in_ready, fifo_count} !== exp_vec()) begin
        n_fail++;
        $display("FAIL fill_push%0d got=%b want=%b", i,
                 {tx, busy, in_ready, fifo_count}, exp_vec());
      end
    end
    n_cmp++;
    if (!saw_full) begin
      n_fail++;
      $display("FAIL fill_full_seen got=0 want=1");
    end
    guard = 0;
    while ((pos >= 0 || q.size() != 0) && guard < 2000) begin
      tick(1'b0, 8'h00, 1'b0);
      guard++;
      n_cmp++;
      if ({tx, busy, in_ready, fifo_count} !== exp_vec()) begin
        n_fail++;
        $display("FAIL fill_drain%0d got=%b want=%b", guard,
                 {tx, busy, in_ready, fifo_count}, exp_vec());
      end
    end
    n_cmp++;
    if (guard >= 2000) begin
      n_fail++;
      $display("FAIL fill_timeout got=%0d want<2000", guard);
    end
  endtask

  task automatic test_random();
    logic v;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 7) == 0);
      tick(v, 8'($urandom), 1'b0);
      n_cmp++;
      if ({tx, busy, in_ready, fifo_count} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random%0d got=%b want=%b", i,
                 {tx, busy, in_ready, fifo_count}, exp_vec());
      end
    end
    for (int i = 0; i < 5 * (FL + 1) + 2; i++) tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    tick(1'b1, 8'h3C, 1'b0);
    tick(1'b1, 8'h11, 1'b0);
    tick(1'b1, 8'h22, 1'b0);
    while (pos != 4 * C + 1 && guard < 200) begin
      tick(1'b0, 8'h00, 1'b0);
      guard++;
    end
    n_cmp++;
    if ({tx, busy, in_ready, fifo_count} !== exp_vec() || guard >= 200) begin
      n_fail++;
      $display("FAIL midreset_pre got=%b want=%b guard=%0d", 
               {tx, busy, in_ready, fifo_count}, exp_vec(), guard);
    end
    tick(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (tx !== 1'b1 || fifo_count !== CNT_W'(0)) begin
      n_fail++;
      $display("FAIL midreset_abort got tx=%b cnt=%0d want 1 0", tx, fifo_count);
    end
    for (int i = 0; i < 3 * FL; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      n_cmp++;
      if ({tx, busy, in_ready, fifo_count} !== {1'b1, 1'b0, 1'b1, CNT_W'(0)}) begin
        n_fail++;
        $display("FAIL midreset_quiet%0d got=%b want=1010..0", i,
                 {tx, busy, in_ready, fifo_count});
      end
    end
  endtask

`ifdef SUM_UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] bytes[2];
    logic       want[2];
    logic       par_obs;
    bytes[0] = 8'h07; want[0] = 1'b1;
    bytes[1] = 8'h03; want[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      par_obs = 1'bx;
      tick(1'b1, bytes[k], 1'b0);
      for (int i = 0; i < FL + 2; i++) begin
        tick(1'b0, 8'h00, 1'b0);
        if (i == 9 * C + C / 2) par_obs = tx;
        n_cmp++;
        if ({tx, busy, in_ready, fifo_count} !== exp_vec()) begin
          n_fail++;
          $display("FAIL parity%0d_cycle%0d got=%b want=%b", k, i,
                   {tx, busy, in_ready, fifo_count}, exp_vec());
        end
      end
      n_cmp++;
      if (par_obs !== want[k]) begin
        n_fail++;
        $display("FAIL parity_bit_%h got=%b want=%b", bytes[k], par_obs, want[k]);
      end
    end
  endtask
`endif

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_single();
    test_fifo_fill();
    test_random();
    test_reset_mid();
`ifdef SUM_UART_TX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_uart_tx.md
Name: sum_uart_tx

Overview:
- Downstream stage of the nibble adder.
- Accepts each 8-bit adder result byte through a valid/ready handshake and buffers it in a small FIFO.
- Serializes each byte onto a single UART TX line (8N1, LSB first) so results can be logged off-chip through a spare IO pin.
- Sits between the adder output register and the uio_out pin driver.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit period; legal values ≥2.
- FIFO_DEPTH, 4, entries in the input FIFO; power of two, ≥2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  result byte from the adder stage.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a byte this cycle.
- tx  output  1  UART serial output; idles high.
- busy  output  1  high when a frame is in progress or the FIFO is non-empty.
- fifo_count  output  clog2(FIFO_DEPTH)+1  number of bytes currently buffered.

Behaviour:
- Single clock domain.
- Reset: synchronous, active-high. On reset, outputs are tx=1, busy=0, fifo_count=0, state=IDLE, and all counters are cleared.
- in_ready = !reset && (fifo_count < FIFO_DEPTH). It is combinational from registered state.
- Push: occurs on a rising edge where in_valid && in_ready. in_data is written at the tail; fifo_count increments next cycle. in_data is ignored when no push occurs.
- Full FIFO: in_ready=0 and the push is refused, even if a pop occurs in the same cycle. There is no bypass path.
- Simultaneous push and pop (FIFO not full): fifo_count is unchanged and data order is preserved.
- Pointers: wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is compiled in).
- IDLE:
  - tx=1.
  - If fifo_count≠0, then at that edge: pop the head into the shift register, set tx=0, clear the bit-timer, and go to START.
- START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx=shift[0].
- DATA:
  - Each bit is held for CLKS_PER_BIT cycles; shift right after each bit.
  - After bit 7 completes, go to STOP with tx=1.
- STOP: hold tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Frame length: exactly 10×CLKS_PER_BIT cycles of tx activity.
- Inter-frame gap: IDLE always lasts at least one cycle between frames. Back-to-back frames are therefore separated by exactly one idle-high cycle.
- Bit-timer: counts 0..CLKS_PER_BIT-1. The bit advances when the timer equals CLKS_PER_BIT-1.
- Bit index: counts 0..7.
- busy = (state≠IDLE) || (fifo_count≠0).
- Reset mid-frame: at the reset edge, the frame is aborted, tx returns to 1, and FIFO contents are discarded (fifo_count=0). No partial byte is resumed.
- The tx output is registered; there is no combinational path from in_* to tx.

Optional Feature:
- Macro: SUM_UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes 11×CLKS_PER_BIT cycles.
- When undefined: no PARITY state exists, and the frame is 8N1 with 10×CLKS_PER_BIT cycles.

Test Plan:
- Reset behaviour (CLKS_PER_BIT=4): hold reset 3 cycles, then release → tx=1, busy=0, fifo_count=0, in_ready=1.
- Single byte (CLKS_PER_BIT=4): push 0xA5 once → tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. Total 40 cycles; busy drops the cycle after STOP ends.
- FIFO fill (FIFO_DEPTH=4, CLKS_PER_BIT=4): push 0x01..0x05 on consecutive cycles with in_valid held high.
  - The first pop happens at the edge after the first push, so all five bytes are accepted without stalling.
  - Bytes are transmitted in order 0x01..0x05, each frame separated by exactly one idle-high cycle.
  - in_ready deasserts while fifo_count=4.
- Simultaneous push/pop: push a new byte on the exact cycle IDLE pops the head → fifo_count unchanged, and the new byte is transmitted after the current one.
- Reset mid-frame: assert reset during DATA bit 3 of 0x3C with 2 bytes queued → tx=1 and fifo_count=0 next cycle, and no further frames are sent.
- Parity (with SUM_UART_TX_PARITY_EN, CLKS_PER_BIT=4): send 0x07 → parity bit=1; send 0x03 → parity bit=0. Each frame is 44 cycles.
